// File: rtl/rom_sqrt_arbiter.sv
// -----------------------------------------------------------------------------
// rom_sqrt_arbiter
//
// Shares one single-port, synchronous-read square-root lookup ROM between
// NUM_REQ requesters. Each requester has a valid/ready request channel. A
// round-robin arbiter grants at most one request per cycle. The ROM access is
// fully pipelined. Results come back on one shared data bus, with a one-hot
// strobe that identifies the requester.
//
// Parameters
//   NUM_REQ      number of requesters (2..8)
//   ADDR_WIDTH   ROM address width
//   DATA_WIDTH   ROM data width
//   ROM_LATENCY  ROM read latency in clocks (1 = no ROM output reg, 2 = reg)
//
// Ports
//   clk          system clock
//   rst_n        asynchronous reset, active low
//   en           1 = grants allowed; 0 = no new grants, pipeline drains
//   req_valid    request valid, one bit per requester
//   req_addr     request addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_ready    grant, one-hot or zero (combinational)
//   rsp_valid    one-hot, 1-cycle response strobe
//   rsp_data     sqrt result, held between responses
//   rom_addr     registered ROM address
//   rom_rd_data  ROM read data
// -----------------------------------------------------------------------------
module rom_sqrt_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int ROM_LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [ADDR_WIDTH-1:0]         rom_addr,
    input  logic [DATA_WIDTH-1:0]         rom_rd_data
);

    localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // One stage covers the address register. The remaining ROM_LATENCY
    // stages track the ROM's own read latency.
    localparam int STAGES = ROM_LATENCY + 1;

    // Requester index (p + k) mod NUM_REQ. This wraps correctly for
    // requester counts that are not a power of two.
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] p,
                                                 input int unsigned     k);
        int unsigned s;
        s = 32'(p) + k;
        return ID_W'(s % NUM_REQ);
    endfunction

    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    gnt_id;
    logic               gnt_any;
    logic [NUM_REQ-1:0] grant;

    logic [STAGES-1:0]  tag_vld;
    logic [ID_W-1:0]    tag_id [STAGES];

    // -------------------------------------------------------------------------
    // Round-robin search. It starts one past the last granted requester.
    // It depends only on req_valid, en and registered state, so there is no
    // path from req_ready back into itself.
    // -------------------------------------------------------------------------
    always_comb begin
        grant   = '0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        if (rst_n && en) begin
            for (int unsigned k = 1; k <= NUM_REQ; k++) begin
                if (!gnt_any && req_valid[wrap_add(rr_ptr, k)]) begin
                    grant[wrap_add(rr_ptr, k)] = 1'b1;
                    gnt_id                     = wrap_add(rr_ptr, k);
                    gnt_any                    = 1'b1;
                end
            end
        end
    end

    assign req_ready = grant;

    // A grant is issued only to a valid requester.
    // The handshake is therefore the same as gnt_any.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= ID_W'(NUM_REQ - 1);
            rom_addr <= '0;
        end else if (gnt_any) begin
            rr_ptr   <= gnt_id;
            rom_addr <= req_addr[32'(gnt_id)*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    // -------------------------------------------------------------------------
    // Tag pipeline. The tags run alongside the ROM access, so that each
    // result is steered to the requester that issued it.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld <= '0;
            for (int unsigned s = 0; s < STAGES; s++) begin
                tag_id[s] <= '0;
            end
        end else begin
            tag_vld   <= {tag_vld[STAGES-2:0], gnt_any};
            tag_id[0] <= gnt_any ? gnt_id : '0;
            for (int unsigned s = 1; s < STAGES; s++) begin
                tag_id[s] <= tag_id[s-1];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output stage. The last tag stage lines up with valid ROM read data.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= '0;
            if (tag_vld[STAGES-1]) begin
                rsp_valid[tag_id[STAGES-1]] <= 1'b1;
                rsp_data                    <= rom_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_rom_sqrt_arbiter.sv
module tb_rom_sqrt_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [3:0]  req_valid;
    logic [31:0] req_addr;

    logic [3:0]  req_ready,  req_ready2;
    logic [3:0]  rsp_valid,  rsp_valid2;
    logic [7:0]  rsp_data,   rsp_data2;
    logic [7:0]  rom_addr,   rom_addr2;
    logic [7:0]  rom_rd_data, rom_rd_data2;

    logic [7:0]  rom_mem [0:255];
    logic [7:0]  rd2a;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rom_sqrt_arbiter #(
        .NUM_REQ(4), .ADDR_WIDTH(8), .DATA_WIDTH(8), .ROM_LATENCY(1)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rom_addr(rom_addr), .rom_rd_data(rom_rd_data)
    );

    rom_sqrt_arbiter #(
        .NUM_REQ(4), .ADDR_WIDTH(8), .DATA_WIDTH(8), .ROM_LATENCY(2)
    ) u_dut2 (
        .clk(clk), .rst_n(rst_n), .en(en),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready2),
        .rsp_valid(rsp_valid2), .rsp_data(rsp_data2),
        .rom_addr(rom_addr2), .rom_rd_data(rom_rd_data2)
    );

    // ROM models: M[a] = floor(16*sqrt(a)) = isqrt(256*a)
    always @(posedge clk) rom_rd_data <= rom_mem[rom_addr];
    always @(posedge clk) begin
        rd2a         <= rom_mem[rom_addr2];
        rom_rd_data2 <= rd2a;
    end

    function automatic int isqrt(input int n);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) <= n) r++;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: check registered outputs, drive inputs, check the grant, advance.
    task automatic step(input string tag, input logic e, input logic [3:0] v,
                        input logic [3:0] erdy, input logic [3:0] ersp,
                        input logic [7:0] edat, input logic [7:0] erom);
        chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(ersp));
        chk({tag, ".rsp_data"},  32'(rsp_data),  32'(edat));
        chk({tag, ".rom_addr"},  32'(rom_addr),  32'(erom));
        en        = e;
        req_valid = v;
        #1;
        chk({tag, ".req_ready"},  32'(req_ready),  32'(erdy));
        chk({tag, ".req_ready2"}, 32'(req_ready2), 32'(erdy));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < 256; a++) rom_mem[a] = 8'(isqrt(256 * a));

        // Reset: req_ready stays low even with en=1 and all requesters valid
        rst_n = 1'b0; en = 1'b1; req_valid = 4'b1111; req_addr = '0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst.rsp_valid", 32'(rsp_valid), 0);
        chk("rst.rsp_data",  32'(rsp_data),  0);
        chk("rst.rom_addr",  32'(rom_addr),  0);
        chk("rst.req_ready", 32'(req_ready), 0);
        req_valid = 4'b0000;
        rst_n = 1'b1;

        // 1: single request, addr 0x40 -> 0x80 at T+3
        req_addr = {8'h00, 8'h00, 8'h00, 8'h40};
        step("t1c0", 1, 4'b0001, 4'b0001, 4'b0000, 8'h00, 8'h00);
        step("t1c1", 1, 4'b0000, 4'b0000, 4'b0000, 8'h00, 8'h40);
        step("t1c2", 1, 4'b0000, 4'b0000, 4'b0000, 8'h00, 8'h40);
        step("t1c3", 1, 4'b0000, 4'b0000, 4'b0001, 8'h80, 8'h40);
        step("t1c4", 1, 4'b0000, 4'b0000, 4'b0000, 8'h80, 8'h40);

        // Reset again so that requester 0 has priority for test 2
        rst_n = 1'b0; #1;
        chk("rst2.rom_addr", 32'(rom_addr), 0);
        chk("rst2.rsp_data", 32'(rsp_data), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 2: all four requesters, addr = id
        req_addr = {8'h03, 8'h02, 8'h01, 8'h00};
        step("t2c0", 1, 4'b1111, 4'b0001, 4'b0000, 8'h00, 8'h00);
        step("t2c1", 1, 4'b1111, 4'b0010, 4'b0000, 8'h00, 8'h00);
        step("t2c2", 1, 4'b1111, 4'b0100, 4'b0000, 8'h00, 8'h01);
        step("t2c3", 1, 4'b1111, 4'b1000, 4'b0001, 8'h00, 8'h02);
        step("t2c4", 1, 4'b1111, 4'b0001, 4'b0010, 8'h10, 8'h03);
        step("t2c5", 1, 4'b0000, 4'b0000, 4'b0100, 8'h16, 8'h00);
        step("t2c6", 1, 4'b0000, 4'b0000, 4'b1000, 8'h1B, 8'h00);
        step("t2c7", 1, 4'b0000, 4'b0000, 4'b0001, 8'h00, 8'h00);
        step("t2c8", 1, 4'b0000, 4'b0000, 4'b0000, 8'h00, 8'h00);

        // 3: only requesters 1 and 3
        step("t3c0", 1, 4'b1010, 4'b0010, 4'b0000, 8'h00, 8'h00);
        step("t3c1", 1, 4'b1010, 4'b1000, 4'b0000, 8'h00, 8'h01);
        step("t3c2", 1, 4'b1010, 4'b0010, 4'b0000, 8'h00, 8'h03);
        step("t3c3", 1, 4'b1010, 4'b1000, 4'b0010, 8'h10, 8'h01);
        step("t3c4", 1, 4'b0000, 4'b0000, 4'b1000, 8'h1B, 8'h03);
        step("t3c5", 1, 4'b0000, 4'b0000, 4'b0010, 8'h10, 8'h03);
        step("t3c6", 1, 4'b0000, 4'b0000, 4'b1000, 8'h1B, 8'h03);
        step("t3c7", 1, 4'b0000, 4'b0000, 4'b0000, 8'h1B, 8'h03);

        // 4: en=0 for 5 cycles, 2 in flight (0,1), 2 pending (2,3)
        step("t4c0",  1, 4'b1111, 4'b0001, 4'b0000, 8'h1B, 8'h03);
        step("t4c1",  1, 4'b1110, 4'b0010, 4'b0000, 8'h1B, 8'h00);
        step("t4c2",  0, 4'b1100, 4'b0000, 4'b0000, 8'h1B, 8'h01);
        step("t4c3",  0, 4'b1100, 4'b0000, 4'b0001, 8'h00, 8'h01);
        step("t4c4",  0, 4'b1100, 4'b0000, 4'b0010, 8'h10, 8'h01);
        step("t4c5",  0, 4'b1100, 4'b0000, 4'b0000, 8'h10, 8'h01);
        step("t4c6",  0, 4'b1100, 4'b0000, 4'b0000, 8'h10, 8'h01);
        step("t4c7",  1, 4'b1100, 4'b0100, 4'b0000, 8'h10, 8'h01);
        step("t4c8",  1, 4'b1000, 4'b1000, 4'b0000, 8'h10, 8'h02);
        step("t4c9",  1, 4'b0000, 4'b0000, 4'b0000, 8'h10, 8'h03);
        step("t4c10", 1, 4'b0000, 4'b0000, 4'b0100, 8'h16, 8'h03);
        step("t4c11", 1, 4'b0000, 4'b0000, 4'b1000, 8'h1B, 8'h03);
        step("t4c12", 1, 4'b0000, 4'b0000, 4'b0000, 8'h1B, 8'h03);

        // 5: reset with two requests in flight
        req_addr = {8'h03, 8'h02, 8'h01, 8'h40};
        step("t5c0", 1, 4'b1111, 4'b0001, 4'b0000, 8'h1B, 8'h03);
        step("t5c1", 1, 4'b1110, 4'b0010, 4'b0000, 8'h1B, 8'h40);
        rst_n = 1'b0; #1;
        chk("t5rst.rsp_valid", 32'(rsp_valid), 0);
        chk("t5rst.rsp_data",  32'(rsp_data),  0);
        chk("t5rst.rom_addr",  32'(rom_addr),  0);
        chk("t5rst.req_ready", 32'(req_ready), 0);
        req_valid = 4'b0000;
        @(posedge clk); #1;
        rst_n = 1'b1;
        step("t5s0", 1, 4'b0000, 4'b0000, 4'b0000, 8'h00, 8'h00);
        step("t5s1", 1, 4'b0000, 4'b0000, 4'b0000, 8'h00, 8'h00);
        step("t5s2", 1, 4'b0000, 4'b0000, 4'b0000, 8'h00, 8'h00);
        step("t5s3", 1, 4'b0000, 4'b0000, 4'b0000, 8'h00, 8'h00);
        step("t5g0", 1, 4'b1111, 4'b0001, 4'b0000, 8'h00, 8'h00);
        step("t5g1", 1, 4'b0000, 4'b0000, 4'b0000, 8'h00, 8'h40);
        step("t5g2", 1, 4'b0000, 4'b0000, 4'b0000, 8'h00, 8'h40);
        step("t5g3", 1, 4'b0000, 4'b0000, 4'b0001, 8'h80, 8'h40);
        step("t5g4", 1, 4'b0000, 4'b0000, 4'b0000, 8'h80, 8'h40);

        // 6: requester 2, addr 0x90 -> 0xC0; latency-2 build answers at T+4
        req_addr = {8'h00, 8'h90, 8'h00, 8'h00};
        step("t6c0", 1, 4'b0100, 4'b0100, 4'b0000, 8'h80, 8'h40);
        chk("t6c1.l2.rom_addr",  32'(rom_addr2),  32'h90);
        chk("t6c1.l2.rsp_valid", 32'(rsp_valid2), 0);
        step("t6c1", 1, 4'b0000, 4'b0000, 4'b0000, 8'h80, 8'h90);
        chk("t6c2.l2.rsp_valid", 32'(rsp_valid2), 0);
        step("t6c2", 1, 4'b0000, 4'b0000, 4'b0000, 8'h80, 8'h90);
        chk("t6c3.l2.rsp_valid", 32'(rsp_valid2), 0);
        chk("t6c3.l2.rsp_data",  32'(rsp_data2),  32'h80);
        step("t6c3", 1, 4'b0000, 4'b0000, 4'b0100, 8'hC0, 8'h90);
        chk("t6c4.l2.rsp_valid", 32'(rsp_valid2), 32'b0100);
        chk("t6c4.l2.rsp_data",  32'(rsp_data2),  32'hC0);
        step("t6c4", 1, 4'b0000, 4'b0000, 4'b0000, 8'hC0, 8'h90);
        chk("t6c5.l2.rsp_valid", 32'(rsp_valid2), 0);
        chk("t6c5.l2.rsp_data",  32'(rsp_data2),  32'hC0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
